data_bus_bridge: RTL and testbench

- Registered bridge between the RISC-V core data port and the data-side port of the RAM.
- Accepts one core load/store at a time and checks it: address range and byte-lane pattern.
- Legal accesses are forwarded to RAM with the request held stable until RAM completes. Illegal accesses are answered locally with a bus error.
- Completion is returned to the core as a begin/end handshake. A saturating error counter is kept for debug.

---
 rtl/data_bus_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_data_bus_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge
//
// Registered bridge between the core data port and the RAM data-side port.
// One access is in flight at a time. Each accepted request is checked for
// address range and byte-lane pattern. Legal accesses are forwarded to RAM
// with the request held stable until ram_end. Illegal accesses are answered
// locally with a bus error. A saturating error counter is kept for debug.
//
// Optional feature (compile-time macro BUS_TIMEOUT_EN):
//   defined   - a wait counter aborts a RAM access that has not completed
//               after TIMEOUT cycles and answers it with a bus error.
//   undefined - the bridge waits for ram_end indefinitely.
//
// Parameters:
//   RAM_SIZE  RAM size in bytes; legal addresses are 0 .. RAM_SIZE-1
//   TIMEOUT   max RAM wait cycles (BUS_TIMEOUT_EN only)
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   core_require        core requests an access
//   core_write_enable   1 = store, 0 = load
//   core_byte_map       byte-lane enables
//   core_address        byte address
//   core_wdata          store data
//   core_rdata          load data, valid while core_end = 1, else 0
//   core_begin          one-cycle pulse: request accepted
//   core_end            one-cycle pulse: access complete
//   bus_error           qualifies core_end: the access failed
//   ram_require         RAM request, held until ram_end
//   ram_write_enable    RAM store enable
//   ram_byte_map        RAM byte-lane enables
//   ram_address         RAM byte address
//   ram_wdata           RAM store data
//   ram_rdata           RAM load data
//   ram_begin           RAM accepted the request (not used)
//   ram_end             RAM access complete, ram_rdata valid
//   err_count           saturating count of bus errors

module data_bus_bridge #(
    parameter int unsigned RAM_SIZE = 256,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_require,
    input  logic        core_write_enable,
    input  logic [3:0]  core_byte_map,
    input  logic [31:0] core_address,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_begin,
    output logic        core_end,
    output logic        bus_error,
    output logic        ram_require,
    output logic        ram_write_enable,
    output logic [3:0]  ram_byte_map,
    output logic [31:0] ram_address,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_begin,
    input  logic        ram_end,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRamWait,
        StResp,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [3:0]  bmap_q;
    logic [31:0] rdata_q, rdata_d;
    logic        begin_q, begin_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        latch_en;
    logic        err_inc;
    logic        legal_bmap;
    logic        legal_addr;
    logic [31:0] lane_mask;
    logic        timeout_hit;

    // RAM handshake start is informational only.
    logic unused_ram_begin;
    assign unused_ram_begin = ram_begin;

    // ------------------------------------------------------------------
    // Request legality
    // ------------------------------------------------------------------
    always_comb begin
        legal_bmap = 1'b0;
        case (core_byte_map)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: legal_bmap = 1'b1;
            default:                   legal_bmap = 1'b0;
        endcase
    end

    assign legal_addr = (core_address < RAM_SIZE);

    assign lane_mask = {{8{bmap_q[3]}}, {8{bmap_q[2]}}, {8{bmap_q[1]}}, {8{bmap_q[0]}}};

    // ------------------------------------------------------------------
    // Optional RAM wait timeout
    // ------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT >= 16) ? $clog2(TIMEOUT + 1) : 4;

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    // RAM_WAIT is only ever entered from IDLE, so clearing in IDLE gives a
    // count of 0 in the first wait cycle.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == StIdle) begin
            wait_cnt_d = '0;
        end else if (state_q == StRamWait) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
    end

    assign timeout_hit = (state_q == StRamWait) && (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        begin_d  = 1'b0;
        rdata_d  = rdata_q;
        latch_en = 1'b0;
        err_inc  = 1'b0;

        case (state_q)
            StIdle: begin
                if (core_require) begin
                    latch_en = 1'b1;
                    begin_d  = 1'b1;
                    rdata_d  = '0;
                    if (legal_bmap && legal_addr) begin
                        state_d = StRamWait;
                    end else begin
                        state_d = StErr;
                        err_inc = 1'b1;
                    end
                end
            end
            StRamWait: begin
                // ram_end on the timeout edge still completes normally.
                if (ram_end) begin
                    state_d = StResp;
                    rdata_d = we_q ? 32'h0 : (ram_rdata & lane_mask);
                end else if (timeout_hit) begin
                    state_d = StErr;
                    rdata_d = '0;
                    err_inc = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
                rdata_d = '0;
            end
            StErr: begin
                state_d = StIdle;
                rdata_d = '0;
            end
            default: begin
                state_d = StIdle;
                rdata_d = '0;
            end
        endcase

        err_count_d = err_count_q;
        if (err_inc && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            begin_q     <= 1'b0;
            rdata_q     <= '0;
            err_count_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            bmap_q      <= '0;
        end else begin
            state_q     <= state_d;
            begin_q     <= begin_d;
            rdata_q     <= rdata_d;
            err_count_q <= err_count_d;
            if (latch_en) begin
                addr_q  <= core_address;
                wdata_q <= core_wdata;
                we_q    <= core_write_enable;
                bmap_q  <= core_byte_map;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign core_begin = begin_q;
    assign core_end   = (state_q == StResp) || (state_q == StErr);
    assign bus_error  = (state_q == StErr);
    assign core_rdata = rdata_q;
    assign err_count  = err_count_q;

    // RAM side is driven only while a request is outstanding.
    assign ram_require      = (state_q == StRamWait);
    assign ram_write_enable = ram_require & we_q;
    assign ram_byte_map     = ram_require ? bmap_q  : 4'h0;
    assign ram_address      = ram_require ? addr_q  : 32'h0;
    assign ram_wdata        = ram_require ? wdata_q : 32'h0;

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;

    localparam int unsigned RAM_SIZE = 256;
    localparam int unsigned TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_require;
    logic        core_write_enable;
    logic [3:0]  core_byte_map;
    logic [31:0] core_address;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_begin;
    logic        core_end;
    logic        bus_error;
    logic        ram_require;
    logic        ram_write_enable;
    logic [3:0]  ram_byte_map;
    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_begin;
    logic        ram_end;
    logic [7:0]  err_count;

    data_bus_bridge #(
        .RAM_SIZE (RAM_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .core_require      (core_require),
        .core_write_enable (core_write_enable),
        .core_byte_map     (core_byte_map),
        .core_address      (core_address),
        .core_wdata        (core_wdata),
        .core_rdata        (core_rdata),
        .core_begin        (core_begin),
        .core_end          (core_end),
        .bus_error         (bus_error),
        .ram_require       (ram_require),
        .ram_write_enable  (ram_write_enable),
        .ram_byte_map      (ram_byte_map),
        .ram_address       (ram_address),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata),
        .ram_begin         (ram_begin),
        .ram_end           (ram_end),
        .err_count         (err_count)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int errors      = 0;
    int exp_err_cnt = 0;

    typedef struct {
        logic        we;
        logic [3:0]  bmap;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdat;
        bit          exp_illegal;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Legal lane patterns are naturally aligned contiguous groups of 1, 2 or 4 bytes.
    function automatic bit model_legal(input logic [3:0] bmap, input logic [31:0] addr);
        int n  = 0;
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < 4; i++) begin
            if (bmap[i]) begin
                n++;
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (addr >= RAM_SIZE) return 1'b0;
        if (!(n == 1 || n == 2 || n == 4)) return 1'b0;
        if (hi - lo + 1 != n) return 1'b0;
        return (lo % n) == 0;
    endfunction

    function automatic logic [31:0] model_rdata(input logic we, input logic [3:0] bmap,
                                                input logic [31:0] d);
        logic [31:0] r = 32'h0;
        if (we) return 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (bmap[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic do_access(input logic we, input logic [3:0] bmap, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat, input logic [31:0] rdat,
                             input bit exp_illegal, input logic [31:0] exp_rdata,
                             input string tag);
        core_write_enable = we;
        core_byte_map     = bmap;
        core_address      = addr;
        core_wdata        = wdata;
        core_require      = 1'b1;
        tick();
        // Core-side noise while busy must be ignored.
        core_require      = 1'($urandom);
        core_address      = $urandom;
        core_wdata        = $urandom;
        core_byte_map     = 4'($urandom);
        core_write_enable = 1'($urandom);
        chk({tag, ".begin"}, core_begin, 1);
        if (exp_illegal) begin
            if (exp_err_cnt < 255) exp_err_cnt++;
            chk({tag, ".err_end"}, core_end, 1);
            chk({tag, ".err_buserr"}, bus_error, 1);
            chk({tag, ".err_rdata"}, core_rdata, 0);
            chk({tag, ".err_noram"}, ram_require, 0);
            chk({tag, ".err_count"}, err_count, exp_err_cnt);
        end else begin
            for (int i = 0; i < lat; i++) begin
                if (i > 0) chk({tag, ".begin_pulse"}, core_begin, 0);
                chk({tag, ".ram_req"}, ram_require, 1);
                chk({tag, ".ram_addr"}, ram_address, addr);
                chk({tag, ".ram_wdata"}, ram_wdata, wdata);
                chk({tag, ".ram_bmap"}, ram_byte_map, bmap);
                chk({tag, ".ram_we"}, ram_write_enable, we);
                chk({tag, ".wait_end"}, core_end, 0);
                ram_end   = (i == lat - 1);
                ram_rdata = (i == lat - 1) ? rdat : $urandom;
                tick();
            end
            ram_end   = 1'b0;
            ram_rdata = $urandom;
            chk({tag, ".end"}, core_end, 1);
            chk({tag, ".buserr"}, bus_error, 0);
            chk({tag, ".rdata"}, core_rdata, exp_rdata);
            chk({tag, ".ram_req_off"}, ram_require, 0);
            chk({tag, ".err_count"}, err_count, exp_err_cnt);
        end
        core_require = 1'b0;
        tick();
        chk({tag, ".idle_end"}, core_end, 0);
        chk({tag, ".idle_begin"}, core_begin, 0);
        chk({tag, ".idle_rdata"}, core_rdata, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'b1111, 32'h10,       32'h0,        1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 4'b1100, 32'h22,       32'h12340000, 3, 32'h55555555, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 4'b1111, 32'h100,      32'h0,        1, 32'h0,        1'b1, 32'h0};
        vecs[3]  = '{1'b0, 4'b0101, 32'h10,       32'h0,        1, 32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b0, 4'b0010, 32'h20,       32'h0,        2, 32'hAABBCCDD, 1'b0, 32'h0000CC00};
        vecs[5]  = '{1'b0, 4'b1000, 32'hFF,       32'h0,        1, 32'h11223344, 1'b0, 32'h11000000};
        vecs[6]  = '{1'b0, 4'b0001, 32'h100,      32'h0,        1, 32'h0,        1'b1, 32'h0};
        vecs[7]  = '{1'b0, 4'b0011, 32'h40,       32'h0,        1, 32'hCAFEF00D, 1'b0, 32'h0000F00D};
        vecs[8]  = '{1'b0, 4'b1100, 32'h44,       32'h0,        4, 32'h55667788, 1'b0, 32'h55660000};
        vecs[9]  = '{1'b0, 4'b0000, 32'h8,        32'h0,        1, 32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b0, 4'b0110, 32'h8,        32'h0,        1, 32'h0,        1'b1, 32'h0};
        vecs[11] = '{1'b1, 4'b0111, 32'h8,        32'h0,        1, 32'h0,        1'b1, 32'h0};
        vecs[12] = '{1'b0, 4'b0100, 32'hFFFFFFFF, 32'h0,        1, 32'h0,        1'b1, 32'h0};
        vecs[13] = '{1'b1, 4'b0001, 32'h0,        32'hA5,       2, 32'hFFFFFFFF, 1'b0, 32'h0};

        reset             = 1'b0;
        core_require      = 1'b1;
        core_write_enable = 1'b0;
        core_byte_map     = 4'b1111;
        core_address      = 32'h10;
        core_wdata        = 32'h0;
        ram_rdata         = 32'h0;
        ram_begin         = 1'b0;
        ram_end           = 1'b1;

        // Reset held with a live request: everything stays quiet.
        #1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst.begin", core_begin, 0);
        chk("rst.end", core_end, 0);
        chk("rst.buserr", bus_error, 0);
        chk("rst.rdata", core_rdata, 0);
        chk("rst.ram_req", ram_require, 0);
        chk("rst.ram_addr", ram_address, 0);
        chk("rst.ram_wdata", ram_wdata, 0);
        chk("rst.ram_bmap", ram_byte_map, 0);
        chk("rst.ram_we", ram_write_enable, 0);
        chk("rst.err_count", err_count, 0);

        // First request after release.
        ram_end = 1'b0;
        reset   = 1'b1;
        tick();
        core_require = 1'b0;
        chk("first.begin", core_begin, 1);
        chk("first.ram_req", ram_require, 1);
        ram_end   = 1'b1;
        ram_rdata = 32'h0BADF00D;
        tick();
        ram_end = 1'b0;
        chk("first.end", core_end, 1);
        chk("first.rdata", core_rdata, 32'h0BADF00D);
        tick();
        chk("first.idle", core_end, 0);

        // Directed table.
        for (int v = 0; v < 14; v++) begin
            do_access(vecs[v].we, vecs[v].bmap, vecs[v].addr, vecs[v].wdata, vecs[v].lat,
                      vecs[v].rdat, vecs[v].exp_illegal, vecs[v].exp_rdata,
                      $sformatf("vec%0d", v));
        end

        // Randomized accesses against the reference model.
        for (int r = 0; r < 150; r++) begin
            logic        we;
            logic [3:0]  bmap;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [31:0] rdat;
            int          lat;
            we    = 1'($urandom);
            bmap  = 4'($urandom);
            addr  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
            wdata = $urandom;
            rdat  = $urandom;
            lat   = $urandom_range(1, 4);
            do_access(we, bmap, addr, wdata, lat, rdat, !model_legal(bmap, addr),
                      model_rdata(we, bmap, rdat), $sformatf("rnd%0d", r));
        end

        // Error counter saturation.
        for (int e = 0; e < 300; e++) begin
            do_access(1'b0, 4'b1111, 32'h100, 32'h0, 1, 32'h0, 1'b1, 32'h0, "sat");
        end
        chk("sat.final", err_count, 255);

        // Reset in the middle of a RAM access aborts it without a response.
        core_write_enable = 1'b0;
        core_byte_map     = 4'b1111;
        core_address      = 32'h30;
        core_require      = 1'b1;
        tick();
        core_require = 1'b0;
        chk("abort.ram_req", ram_require, 1);
        tick();
        #2;
        reset = 1'b0;
        #1;
        exp_err_cnt = 0;
        chk("abort.ram_req_off", ram_require, 0);
        chk("abort.end", core_end, 0);
        chk("abort.err_count", err_count, 0);
        reset   = 1'b1;
        ram_end = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort.no_end", core_end, 0);
            chk("abort.no_ram", ram_require, 0);
        end
        ram_end = 1'b0;

        // RAM that never answers.
        begin
            int waited;
            waited       = 0;
            core_address = 32'h30;
            core_require = 1'b1;
            tick();
            core_require = 1'b0;
            while (ram_require && waited < 40) begin
                waited++;
                tick();
            end
`ifdef BUS_TIMEOUT_EN
            exp_err_cnt++;
            chk("tmo.cycles", waited, TIMEOUT);
            chk("tmo.end", core_end, 1);
            chk("tmo.buserr", bus_error, 1);
            chk("tmo.rdata", core_rdata, 0);
            chk("tmo.err_count", err_count, exp_err_cnt);
            tick();
            // ram_end on the timeout edge wins.
            core_require = 1'b1;
            tick();
            core_require = 1'b0;
            for (int i = 0; i < TIMEOUT; i++) begin
                ram_end   = (i == TIMEOUT - 1);
                ram_rdata = 32'h600DCAFE;
                tick();
            end
            ram_end = 1'b0;
            chk("tmo_win.end", core_end, 1);
            chk("tmo_win.buserr", bus_error, 0);
            chk("tmo_win.rdata", core_rdata, 32'h600DCAFE);
            tick();
`else
            chk("hang.cycles", waited, 40);
            chk("hang.ram_req", ram_require, 1);
            chk("hang.end", core_end, 0);
            #2;
            reset = 1'b0;
            #2;
            reset = 1'b1;
            tick();
            chk("hang.cleared", ram_require, 0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
